majority_vote_ctrl: RTL and testbench
=====================================

Name: majority_vote_ctrl

Overview:
- Sequencing controller for the 13-ballot, 4-bit majority detector datapath.
- Collects NUM_VOTERS 4-bit ballots serially over a valid/ready handshake and tallies them per candidate (codes 0..15).
- Scans the tallies sequentially and reports the winning code, its count, and flag f (strict majority reached).
- Sits between the ballot source and downstream consumers; one round per start pulse.

Parameters:
- NUM_VOTERS, 13, ballots accepted per round (1..255).
- CNT_W, $clog2(NUM_VOTERS+1), width of each tally counter and of win_count.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse; clears tallies and begins a round.
- in_valid  input  1  ballot present.
- in_ballot  input  4  ballot value (candidate code).
- in_ready  output  1  controller accepts a ballot this cycle.
- busy  output  1  round in progress (COLLECT or EVAL).
- result_valid  output  1  result fields valid; held until next start.
- winner  output  4  candidate with the highest tally.
- win_count  output  CNT_W  tally of winner.
- f  output  1  majority flag: 2*win_count > counted ballots.

Behaviour:
- Reset (async, rst=1): state IDLE; all tallies 0; in_ready=0, busy=0, result_valid=0, winner=0, win_count=0, f=0, accepted count=0.
- States: IDLE, COLLECT, EVAL, DONE.
- IDLE: in_ready=0; in_valid ignored. start -> COLLECT next cycle; tallies and accepted count cleared on the start edge.
- COLLECT: in_ready=1, busy=1. Handshake fires when in_valid & in_ready. That cycle, tally[in_ballot] increments and accepted count increments. When the accepted count reaches NUM_VOTERS, the state becomes EVAL the following cycle and in_ready drops the same cycle (no extra ballot accepted).
- EVAL: in_ready=0, busy=1. Exactly 16 cycles, candidate index 0..15, one per cycle. Running max updates only when tally > current max (strict), so ties resolve to the lowest code.
- EVAL -> DONE after index 15.
- DONE: result_valid=1, busy=0; winner, win_count and f are registered and stable.
- Latency: last handshake at cycle N gives result_valid=1 at cycle N+17.
- f = (2*win_count > NUM_VOTERS). Compute at CNT_W+1 bits; no overflow.
- start in DONE: result_valid, winner, win_count and f clear to 0 next cycle; new round begins in COLLECT.
- start in COLLECT or EVAL: abort, clear tallies, restart COLLECT. Any ballot handshake in the same cycle is discarded (start wins).
- in_valid with an X or illegal value is not possible: all 16 codes are legal.
- Counter saturation is impossible because each tally is at most NUM_VOTERS.
- rst asserted mid-round: immediate return to reset values; the partial round is lost.

Optional Feature:
- Macro: MAJ_ABSTAIN_EN.
- Defined: ballot 4'hF is an abstention.
  - It counts toward NUM_VOTERS accepted.
  - It does not increment any tally.
  - EVAL scans codes 0..14 only (15 cycles, result at N+16).
  - f = (2*win_count > NUM_VOTERS - abstain_count).
  - If every ballot abstains: winner=0, win_count=0, f=0.
- Undefined: 4'hF is an ordinary candidate; behaviour as above.

Decomposition:
- Package maj_pkg holds:
  - state enum maj_state_t {IDLE, COLLECT, EVAL, DONE};
  - NUM_CAND=16;
  - ABSTAIN_CODE=4'hF;
  - cand_t typedef (logic [3:0]).
- Sub-module maj_tally_bank: 16 CNT_W counters with synchronous clear, increment-by-index, and read-by-index port. The controller FSM stays in majority_vote_ctrl.

Test Plan:
- Reset then idle: rst pulse, in_valid=1 with no start -> in_ready=0, all outputs 0, no tally change.
- Clear majority: start, 13 ballots {7×4'h5, 6×4'h2}, in_valid held high -> result_valid at last handshake+17, winner=5, win_count=7, f=1.
- No majority with tie: 13 ballots {4×4'h3, 4×4'h1, 5 distinct others} -> winner=1, win_count=4, f=0 (lowest code wins tie).
- Backpressure gaps: same as the clear-majority case with in_valid toggled randomly -> identical result; exactly 13 handshakes; in_ready=0 after the 13th.
- Abort and reset mid-round: start, 6 ballots of 4'h9, start again, 13 ballots of 4'hA -> winner=A, win_count=13, f=1. Separately, rst during EVAL -> all outputs 0 immediately.
- MAJ_ABSTAIN_EN: 13 ballots {5×4'hF, 5×4'h4, 3×4'h0} -> winner=4, win_count=5, f=1 (5*2 > 8). All 13 ballots 4'hF -> winner=0, win_count=0, f=0.

Source files
------------

// File: rtl/maj_pkg.sv
// maj_pkg: shared types and constants for the majority vote controller.
// Optional feature macro MAJ_ABSTAIN_EN is consumed by majority_vote_ctrl.
package maj_pkg;
    typedef enum logic [1:0] {IDLE, COLLECT, EVAL, DONE} maj_state_t;
    localparam int NUM_CAND = 16;
    localparam logic [3:0] ABSTAIN_CODE = 4'hF;
    typedef logic [3:0] cand_t;
endpackage

// File: rtl/maj_tally_bank.sv
// maj_tally_bank: 16 per-candidate tally counters.
// Ports: clk/rst (async active-high), clr (sync clear of all tallies, wins over inc),
//        inc + inc_idx (increment one tally), rd_idx -> rd_cnt (combinational read).
module maj_tally_bank
    import maj_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [3:0]       inc_idx,
    input  logic [3:0]       rd_idx,
    output logic [CNT_W-1:0] rd_cnt
);
    logic [CNT_W-1:0] tally [NUM_CAND];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CAND; i++) tally[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < NUM_CAND; i++) tally[i] <= '0;
        end else if (inc) begin
            tally[inc_idx] <= tally[inc_idx] + CNT_W'(1);
        end
    end

    assign rd_cnt = tally[rd_idx];
endmodule

// File: rtl/majority_vote_ctrl.sv
// majority_vote_ctrl: collects NUM_VOTERS 4-bit ballots, tallies them, scans for the winner.
// Ports: clk, rst (async active-high), start (begin/abort round), in_valid/in_ballot/in_ready
//        (ballot handshake), busy, result_valid, winner, win_count, f (strict majority).
// Macro MAJ_ABSTAIN_EN: ballot 4'hF abstains (counted as accepted, never tallied, not scanned).
module majority_vote_ctrl
    import maj_pkg::*;
#(
    parameter int NUM_VOTERS = 13,
    parameter int CNT_W      = $clog2(NUM_VOTERS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [3:0]       in_ballot,
    output logic             in_ready,
    output logic             busy,
    output logic             result_valid,
    output logic [3:0]       winner,
    output logic [CNT_W-1:0] win_count,
    output logic             f
);
`ifdef MAJ_ABSTAIN_EN
    localparam cand_t LAST_IDX = 4'd14;
`else
    localparam cand_t LAST_IDX = 4'd15;
`endif
    localparam logic [CNT_W-1:0] LAST_ACC = CNT_W'(NUM_VOTERS - 1);
    localparam logic [CNT_W:0]   NV_W     = (CNT_W+1)'(NUM_VOTERS);

    maj_state_t       state, state_nx;
    logic [CNT_W-1:0] acc, max_cnt, rd_cnt, best_cnt;
    logic [3:0]       idx, max_idx, best_idx;
    logic [CNT_W:0]   thresh;
    logic             fire, upd, maj, tally_inc;

    assign in_ready     = state == COLLECT;
    assign busy         = state == COLLECT || state == EVAL;
    assign result_valid = state == DONE;
    // start wins over a coincident ballot
    assign fire         = in_valid && in_ready && !start;
    // strict compare keeps the earliest (lowest) code on ties
    assign upd          = rd_cnt > max_cnt;
    assign best_cnt     = upd ? rd_cnt : max_cnt;
    assign best_idx     = upd ? idx : max_idx;
    assign maj          = {best_cnt, 1'b0} > thresh;

`ifdef MAJ_ABSTAIN_EN
    logic [CNT_W-1:0] abst;
    assign tally_inc = fire && in_ballot != ABSTAIN_CODE;
    assign thresh    = NV_W - {1'b0, abst};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) abst <= '0;
        else if (start) abst <= '0;
        else if (fire && in_ballot == ABSTAIN_CODE) abst <= abst + CNT_W'(1);
    end
`else
    assign tally_inc = fire;
    assign thresh    = NV_W;
`endif

    maj_tally_bank #(.CNT_W(CNT_W)) u_bank (
        .clk     (clk),
        .rst     (rst),
        .clr     (start),
        .inc     (tally_inc),
        .inc_idx (in_ballot),
        .rd_idx  (idx),
        .rd_cnt  (rd_cnt)
    );

    always_comb begin
        state_nx = state;
        state_nx = start ? COLLECT :
                   (state == COLLECT && fire && acc == LAST_ACC) ? EVAL :
                   (state == EVAL && idx == LAST_IDX) ? DONE : state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            idx       <= '0;
            max_cnt   <= '0;
            max_idx   <= '0;
            winner    <= '0;
            win_count <= '0;
            f         <= 1'b0;
        end else begin
            state <= state_nx;
            if (start) begin
                acc       <= '0;
                idx       <= '0;
                max_cnt   <= '0;
                max_idx   <= '0;
                winner    <= '0;
                win_count <= '0;
                f         <= 1'b0;
            end else begin
                if (fire) acc <= acc + CNT_W'(1);
                if (state == EVAL) begin
                    idx     <= idx + 4'd1;
                    max_cnt <= best_cnt;
                    max_idx <= best_idx;
                    if (idx == LAST_IDX) begin
                        winner    <= best_idx;
                        win_count <= best_cnt;
                        f         <= maj;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_majority_vote_ctrl.sv
// tb_majority_vote_ctrl: directed self-checking bench with a result scoreboard.
module tb_majority_vote_ctrl;
    localparam int NV = 13;
    localparam int CW = $clog2(NV + 1);
`ifdef MAJ_ABSTAIN_EN
    localparam int LAT = 16;
    localparam int ABS_EN = 1;
`else
    localparam int LAT = 17;
    localparam int ABS_EN = 0;
`endif

    logic          clk = 1'b0;
    logic          rst, start, in_valid;
    logic [3:0]    in_ballot;
    logic          in_ready, busy, result_valid, f;
    logic [3:0]    winner;
    logic [CW-1:0] win_count;

    majority_vote_ctrl #(.NUM_VOTERS(NV)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_ballot    (in_ballot),
        .in_ready     (in_ready),
        .busy         (busy),
        .result_valid (result_valid),
        .winner       (winner),
        .win_count    (win_count),
        .f            (f)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int hs_cnt = 0;
    always @(posedge clk) cyc++;
    always @(posedge clk) if (in_valid && in_ready) hs_cnt++;

    typedef struct {
        int w;
        int c;
        int f;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] bq[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         hs_cyc = 0;
    int         base = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model();
        int   t[16];
        int   ab = 0;
        int   last = ABS_EN ? 14 : 15;
        exp_t e = '{0, 0, 0};
        foreach (t[k]) t[k] = 0;
        foreach (bq[k]) begin
            if (ABS_EN != 0 && bq[k] == 4'hF) ab++;
            else t[bq[k]]++;
        end
        for (int k = 0; k <= last; k++)
            if (t[k] > e.c) begin
                e.w = k;
                e.c = t[k];
            end
        e.f = (2 * e.c > NV - ab) ? 1 : 0;
        return e;
    endfunction

    // all tasks are entered and left on a falling edge
    task automatic pulse_start();
        start = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [3:0] b, input bit gaps);
        bit done = 0;
        for (int t = 0; t < 200 && !done; t++) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_ballot = b;
            if (in_valid && in_ready) begin
                hs_cyc = cyc;
                done = 1;
            end
            @(negedge clk);
        end
        if (!done) chk("handshake timeout", in_ready, 1);
    endtask

    task automatic send_round(input bit gaps, input bit push);
        base = hs_cnt;
        foreach (bq[k]) send(bq[k], gaps);
        if (push) sb.push_back(model());
    endtask

    task automatic wait_result();
        exp_t e;
        bit   seen = 0;
        for (int t = 0; t < 60 && !seen; t++) begin
            if (result_valid) seen = 1;
            else @(negedge clk);
        end
        chk("result_valid", result_valid, 1);
        chk("latency", cyc - hs_cyc, LAT);
        e = sb.pop_front();
        chk("winner", winner, e.w);
        chk("win_count", win_count, e.c);
        chk("f", f, e.f);
        chk("busy in DONE", busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_ballot = 4'h0;
        repeat (2) @(negedge clk);
        in_valid = 1'b1;
        in_ballot = 4'h7;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle in_ready", in_ready, 0);
        chk("idle busy", busy, 0);
        chk("idle result_valid", result_valid, 0);
        chk("idle winner", winner, 0);
        chk("idle win_count", win_count, 0);
        chk("idle f", f, 0);
        chk("idle handshakes", hs_cnt, 0);

        // clear majority, in_valid held high past the last ballot
        pulse_start();
        chk("collect busy", busy, 1);
        chk("collect in_ready", in_ready, 1);
        bq = '{4'h5, 4'h2, 4'h5, 4'h2, 4'h5, 4'h2, 4'h5, 4'h2, 4'h5, 4'h2, 4'h5, 4'h2, 4'h5};
        send_round(0, 1);
        chk("in_ready after last", in_ready, 0);
        wait_result();
        chk("handshakes clear", hs_cnt - base, NV);
        in_valid = 1'b0;

        // tie on count 4: lowest code wins, no majority
        pulse_start();
        chk("restart result_valid", result_valid, 0);
        chk("restart winner", winner, 0);
        chk("restart win_count", win_count, 0);
        chk("restart f", f, 0);
        bq = '{4'h3, 4'h1, 4'h0, 4'h3, 4'h1, 4'h2, 4'h3, 4'h1, 4'h4, 4'h3, 4'h1, 4'h6, 4'h8};
        send_round(0, 1);
        wait_result();

        // backpressure gaps
        pulse_start();
        bq = '{4'h5, 4'h2, 4'h5, 4'h2, 4'h5, 4'h2, 4'h5, 4'h2, 4'h5, 4'h2, 4'h5, 4'h2, 4'h5};
        send_round(1, 1);
        in_valid = 1'b1;
        chk("in_ready after last gaps", in_ready, 0);
        wait_result();
        chk("handshakes gaps", hs_cnt - base, NV);
        in_valid = 1'b0;

        // abort mid-collect then full round
        pulse_start();
        bq = '{4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9};
        send_round(0, 0);
        in_valid = 1'b0;
        pulse_start();
        bq = '{13{4'hA}};
        send_round(0, 1);
        in_valid = 1'b0;
        wait_result();

        // async reset while DONE clears results without a clock edge
        #2 rst = 1'b1;
        #1;
        chk("rst DONE result_valid", result_valid, 0);
        chk("rst DONE winner", winner, 0);
        chk("rst DONE win_count", win_count, 0);
        chk("rst DONE f", f, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // async reset during EVAL
        pulse_start();
        bq = '{13{4'h5}};
        send_round(0, 0);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("eval busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst EVAL busy", busy, 0);
        chk("rst EVAL in_ready", in_ready, 0);
        chk("rst EVAL result_valid", result_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("lost round result_valid", result_valid, 0);
        chk("lost round win_count", win_count, 0);

        // code F as abstention (or ordinary candidate when the feature is off)
        pulse_start();
        bq = '{4'hF, 4'h4, 4'h0, 4'hF, 4'h4, 4'h0, 4'hF, 4'h4, 4'h0, 4'hF, 4'h4, 4'hF, 4'h4};
        send_round(0, 1);
        in_valid = 1'b0;
        wait_result();

        pulse_start();
        bq = '{13{4'hF}};
        send_round(0, 1);
        in_valid = 1'b0;
        wait_result();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
